choquet_lambda_acc: RTL
=======================

// Module: choquet_lambda_acc
// PURPOSE
// - Consumes the descending-sorted stream (value, index) from the bit-serial sorter and computes a
//   discrete Choquet integral over a lambda-fuzzy measure.
// - Per-element densities g_i live in an internal RAM loaded over a write port.
// - Measure recursion: g(A_k) = g(A_k-1) + g_i + lambda*g(A_k-1)*g_i
// - Integral: C = sum x_(k) * (g(A_k) - g(A_k-1))
// - One result per frame of N sorted samples, reported to the measurement/host logic.
// PARAMETERS
// - N       250  samples per frame; legal indices 1..N
// - LENGTH  32   sample width, unsigned
// - IDX_W   9    index width
// - OUT_W   48   integer width of choquet_out
// PORTS
// - clk          in   1       system clock
// - rst_n        in   1       synchronous reset, active low
// - in_val       in   1       sorted sample strobe (sorter result_val); at most one per cycle, back-to-back allowed
// - in_data      in   LENGTH  sorted sample (sorter result)
// - in_index     in   IDX_W   original position of sample (sorter result_index), 1..N
// - lambda       in   24      signed Q7.16 measure parameter; sampled on the first in_val of a frame, held for that frame
// - den_wr       in   1       density RAM write strobe
// - den_addr     in   IDX_W   density address 1..N
// - den_data     in   16      density g_i, unsigned Q0.16
// - den_busy     out  1       high while a frame is in progress; den_wr is ignored then
// - choquet_out  out  OUT_W   integer part of C (accumulator bits [OUT_W+15:16]), truncated
// - out_val      out  1       one-cycle pulse, choquet_out valid
// - frame_cnt    out  IDX_W   samples accepted in current frame
// - err          out  1       sticky duplicate/range error (macro only, else tied 0)
// BEHAVIOUR
// - Reset: choquet_out=0, out_val=0, den_busy=0, frame_cnt=0, err=0, g=0, acc=0, FSM=IDLE.
//   Density RAM contents are not cleared.
// - FSM IDLE -> RUN on in_val (frame_cnt<=1, lambda latched).
// - RUN counts each in_val. After the N-th in_val: RUN -> FLUSH (2 cycles, pipeline drain)
//   -> DONE (out_val=1 for 1 cycle, choquet_out updated) -> IDLE.
//   g, acc, frame_cnt clear on leaving DONE.
// - Pipeline:
//   - S1: register x and index; issue RAM read.
//   - S2: RAM read data g_i valid (registered read).
//   - S3: g_new and acc update in one cycle.
// - Latency: out_val asserts on the 4th rising edge after the edge sampling the N-th in_val.
// - Arithmetic:
//   - p = (g*g_i)>>16
//   - q = (lambda*p)>>>16, arithmetic shift
//   - g_new = g + g_i + q, clamped to [g, 0x10000]. Monotone; 1.0 ceiling.
//   - delta = g_new - g, 0..0x10000.
//   - acc (64b unsigned) += x*delta, exact.
//   - choquet_out truncated, no rounding.
// - den_wr in IDLE writes RAM[den_addr].
// - den_wr in RUN/FLUSH/DONE is dropped and den_busy=1.
// - den_addr 0 or >N: write ignored.
// - in_val during FLUSH/DONE starts no new frame and the sample is discarded.
//   Sorter output gaps cover this.
// - in_index 0 or >N: density read as 0, sample still counted.
// - rst_n low mid-frame: frame abandoned, no out_val.
// - lambda changes mid-frame have no effect until the next frame.
// CONFIGURATION
// - CHOQUET_DUP_CHECK_EN defined:
//   - N-bit seen bitmap, cleared at frame start.
//   - in_val with an index already seen, or out of range, sets err (sticky until reset).
//   - The sample still counts.
//   - Bitmap cleared on DONE.
// - CHOQUET_DUP_CHECK_EN undefined: no bitmap; err tied 0.
// TESTING (N=4 unless noted, densities 0x4000 each)
// - Additive case: lambda=0, samples (400,i1)(300,i2)(200,i3)(100,i4) back-to-back
//   -> out_val once, choquet_out=250, 4 cycles after last in_val.
// - Super-additive case: lambda=0x010000, same samples
//   -> g: 0x4000, 0x9000, 0xF400, clamp 0x10000 -> choquet_out=276.
// - Write during frame: den_wr to addr 2 with 0xFFFF while den_busy=1
//   -> RAM unchanged; the next frame with lambda=0 again yields 250.
// - Reset mid-frame: rst_n low after 2 samples, then a full frame -> only one out_val, value 250.
// - Gapped stream: samples with 0-5 idle cycles between in_val -> same results as back-to-back; frame_cnt steps 1..4.
// - Macro on: index 3 sent twice -> err=1 and stays 1; macro off: err=0.

Source files
------------

// File: rtl/choquet_lambda_acc.sv
// Discrete Choquet integral over a lambda-fuzzy measure, fed by a descending
// sorted (value, index) stream. Densities g_i sit in an internal RAM that is
// loaded while no frame is in progress.
// Optional feature: define CHOQUET_DUP_CHECK_EN to enable the per-frame seen
// bitmap and the sticky duplicate/range error flag (otherwise err is tied 0).
module choquet_lambda_acc #(
  parameter int N      = 250,
  parameter int LENGTH = 32,
  parameter int IDX_W  = 9,
  parameter int OUT_W  = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_val,
  input  logic [LENGTH-1:0]   in_data,
  input  logic [IDX_W-1:0]    in_index,
  input  logic signed [23:0]  lambda,
  input  logic                den_wr,
  input  logic [IDX_W-1:0]    den_addr,
  input  logic [15:0]         den_data,
  output logic                den_busy,
  output logic [OUT_W-1:0]    choquet_out,
  output logic                out_val,
  output logic [IDX_W-1:0]    frame_cnt,
  output logic                err
);

  localparam int AW = $clog2(N + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH_A, FLUSH_B, DONE} state_t;

  state_t state, state_nxt;
  logic   accept, frame_start, frame_end;

  logic signed [23:0] lambda_q;
  logic               idx_ok, wr_ok;

  // pipeline registers
  logic              s1_val, s1_ok;
  logic [LENGTH-1:0] s1_x;
  logic [AW-1:0]     s1_addr;
  logic              s2_val, s2_ok;
  logic [LENGTH-1:0] s2_x;
  logic [15:0]       s2_gi_raw;

  // measure / accumulator state
  logic [16:0] g;
  logic [63:0] acc;

  // S3 combinational arithmetic
  logic [15:0]        gi;
  logic [32:0]        gg;
  logic [16:0]        p;
  logic signed [41:0] lp;
  logic signed [25:0] q;
  logic signed [27:0] sum, g_ext;
  logic [16:0]        g_new, delta;
  logic [63:0]        contrib;

  logic [15:0] den_ram [0:N];

  assign idx_ok   = (in_index != '0) && (in_index <= LAST);
  assign wr_ok    = (den_addr != '0) && (den_addr <= LAST);
  assign den_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_nxt   = state;
    accept      = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: if (in_val) begin
        accept      = 1'b1;
        frame_start = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        // One idle RUN cycle after the N-th sample lines the drain up with the 4-edge latency.
        if (frame_cnt == LAST) state_nxt = FLUSH_A;
        else if (in_val)       accept    = 1'b1;
      end
      FLUSH_A: state_nxt = FLUSH_B;
      FLUSH_B: state_nxt = DONE;
      DONE: begin
        frame_end = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Density RAM write port; only open while idle.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; densities survive rst_n and must be loaded by the host.
    if (den_wr && (state == IDLE) && wr_ok) den_ram[AW'(den_addr)] <= den_data;
  end

  // S1/S2 pipeline: capture sample, then registered RAM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_val <= 1'b0;
      s2_val <= 1'b0;
    end else begin
      s1_val <= accept;
      s2_val <= s1_val;
    end
    s1_x      <= in_data;
    s1_ok     <= idx_ok;
    s1_addr   <= idx_ok ? AW'(in_index) : '0;
    s2_x      <= s1_x;
    s2_ok     <= s1_ok;
    s2_gi_raw <= den_ram[s1_addr];
  end

  // S3 arithmetic: lambda-measure recursion with monotone clamp and exact product.
  always_comb begin
    gi      = s2_ok ? s2_gi_raw : 16'h0000;
    gg      = 33'(g) * 33'(gi);
    p       = 17'(gg >> 16);
    lp      = 42'(lambda_q) * 42'($signed({1'b0, p}));
    q       = 26'(lp >>> 16);
    g_ext   = $signed({11'b0, g});
    sum     = g_ext + $signed({12'b0, gi}) + 28'(q);
    if (sum < g_ext)              g_new = g;
    else if (sum > 28'sh0010000)  g_new = 17'h10000;
    else                          g_new = 17'(sum);
    delta   = g_new - g;
    contrib = 64'(s2_x) * 64'(delta);
  end

  // Frame bookkeeping, measure/accumulator update and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      lambda_q    <= '0;
      g           <= '0;
      acc         <= '0;
      out_val     <= 1'b0;
      choquet_out <= '0;
    end else begin
      if (frame_start)    frame_cnt <= IDX_W'(1);
      else if (accept)    frame_cnt <= frame_cnt + IDX_W'(1);
      else if (frame_end) frame_cnt <= '0;

      if (frame_start) lambda_q <= lambda;

      if (frame_end) begin
        g   <= '0;
        acc <= '0;
      end else if (s2_val) begin
        g   <= g_new;
        acc <= acc + contrib;
      end

      out_val <= frame_end;
      if (frame_end) choquet_out <= acc[OUT_W+15:16];
    end
  end

`ifdef CHOQUET_DUP_CHECK_EN
  logic [N-1:0]  seen;
  logic [AW-1:0] bit_sel;
  logic          err_q;

  assign bit_sel = AW'(in_index - IDX_W'(1));
  assign err     = err_q;

  // Per-frame seen bitmap and sticky duplicate/out-of-range flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (!idx_ok || (!frame_start && seen[bit_sel])) err_q <= 1'b1;
      if (frame_start)  seen <= idx_ok ? (N'(1) << bit_sel) : '0;
      else if (idx_ok)  seen[bit_sel] <= 1'b1;
    end else if (frame_end) begin
      seen <= '0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
